bouncing_box_gen: RTL and testbench
===================================

// Module: bouncing_box_gen
// PURPOSE
//  Pixel source that sits directly downstream of the VGA horizontal/vertical counters.
//  Consumes the raw H/V count values and produces registered 4-bit RGB for the 640x480 active area.
//  Draws a BOX_SIZE square in the switch colour on a background colour.
//  The square moves STEP pixels per frame and bounces off all four active-area edges.
// PARAMETERS
//  H_ACT_START  144  first active H count (inclusive)
//  H_ACT_END    783  last active H count (inclusive)
//  V_ACT_START  35   first active V count (inclusive)
//  V_ACT_END    514  last active V count (inclusive)
//  BOX_SIZE     32   box edge in pixels; 1..480
//  STEP         2    pixels moved per frame per axis; 1..BOX_SIZE
//  BG_RGB       12'h000  background colour {B,G,R}
// PORTS
//  clk          in   1   25 MHz pixel clock
//  rst_n        in   1   asynchronous active-low reset
//  h_count      in   16  horizontal counter value, 0..799
//  v_count      in   16  vertical counter value, 0..524
//  sw           in   12  box colour: [3:0]=R, [7:4]=G, [11:8]=B
//  pause        in   1   1 = freeze box position
//  Red          out  4   red pixel, registered
//  Green        out  4   green pixel, registered
//  Blue         out  4   blue pixel, registered
//  frame_tick   out  1   1-cycle pulse when the position update is applied
// BEHAVIOUR
//  Reset (async, rst_n=0): Red/Green/Blue=0, frame_tick=0.
//   Reset values: box_x=0, box_y=0, dir_x=+, dir_y=+, state=WAIT.
//  Coordinates: px=h_count-H_ACT_START, py=v_count-V_ACT_START.
//   Box position range: x 0..640-BOX_SIZE, y 0..480-BOX_SIZE.
//  Frame start: the cycle with h_count==0 && v_count==0.
//  FSM:
//   WAIT -> RUN at the first frame start after reset; no movement on that frame.
//   RUN: at each frame start, if pause=1 -> HOLD with no move; else step and pulse frame_tick.
//   HOLD: at each frame start, if pause=0 -> RUN; the move resumes on the next frame start.
//   pause is sampled only at frame start.
//  Step per axis, evaluated in 17-bit arithmetic:
//   nx=box_x+STEP (dir +) or box_x-STEP (dir -).
//   If nx>max: box_x=max and dir flips to -.
//   If nx<0: box_x=0 and dir flips to +.
//   Otherwise box_x=nx.
//   The y axis is independent; a corner hit flips both directions in the same frame.
//  Pixel path, 1-cycle latency (RGB reflects the h/v counts of the previous cycle):
//   Outside the active area: RGB=0.
//   Inside the active area and the box (box_x<=px<box_x+BOX_SIZE, same for y): RGB=sw.
//   Else: RGB=BG_RGB.
//  The position update and the pixel decision use the pre-update position on the frame-start cycle.
//   The frame-start pixel is in blanking, so this is invisible.
//  h_count/v_count values outside their ranges: treated as blanking, no state change.
//  Reset mid-frame: outputs go to 0 immediately and the FSM restarts in WAIT.
// CONFIGURATION
//  BOUNCE_COLOR_EN defined: a colour-invert flag toggles on every frame where any axis bounces.
//   A corner hit toggles the flag once.
//   While the flag is set, box colour = ~sw.
//   The flag resets to 0.
//  BOUNCE_COLOR_EN undefined: box colour is always sw; no flag register exists.
// TESTING
//  T1 reset: rst_n=0 mid-line -> Red/Green/Blue=0 and frame_tick=0 asynchronously.
//   Position reads (0,0) after release.
//  T2 first pixel: after WAIT->RUN, sw=12'hFFF, h=144,v=35 -> next cycle RGB=F/F/F.
//   At h=176,v=35 -> RGB=0/0/0 (BG).
//   At h=100 -> RGB=0.
//  T3 motion: 3 frame starts after reset, pause=0 -> box_x=box_y=4.
//   frame_tick pulsed twice, exactly 1 cycle each.
//  T4 bounce: force box_x=607, dir +, STEP=2 -> box_x=608 and dir -.
//   Next frame -> box_x=606.
//  T5 pause: pause=1 across 5 frame starts -> position unchanged and no frame_tick.
//   Release pause -> movement resumes one frame later.
//  T6 macro: with BOUNCE_COLOR_EN and sw=12'h0F0, after a corner bounce -> box pixel RGB=F/0/F.
//   The next bounce restores 0/F/0.

Source files
------------

// File: rtl/bouncing_box_gen_if.sv
// Pixel-source bus: raw VGA counts, box controls and the registered pixel/tick outputs.
interface bouncing_box_gen_if;
  logic [15:0] h_count;
  logic [15:0] v_count;
  logic [11:0] sw;
  logic        pause;
  logic [3:0]  Red;
  logic [3:0]  Green;
  logic [3:0]  Blue;
  logic        frame_tick;

  // Timing/control side: drives counts and controls, observes pixels.
  modport master (
    output h_count, v_count, sw, pause,
    input  Red, Green, Blue, frame_tick
  );

  // Pixel generator side.
  modport slave (
    input  h_count, v_count, sw, pause,
    output Red, Green, Blue, frame_tick
  );
endinterface

// File: rtl/bouncing_box_gen.sv
// bouncing_box_gen: draws a square that bounces around the 640x480 active area.
// Optional build macro BOUNCE_COLOR_EN: box colour inverts on every frame where an axis bounces.
module bouncing_box_gen #(
  parameter int unsigned H_ACT_START = 144,
  parameter int unsigned H_ACT_END   = 783,
  parameter int unsigned V_ACT_START = 35,
  parameter int unsigned V_ACT_END   = 514,
  parameter int unsigned BOX_SIZE    = 32,
  parameter int unsigned STEP        = 2,
  parameter logic [11:0] BG_RGB      = 12'h000
) (
  input logic               clk,
  input logic               rst_n,
  bouncing_box_gen_if.slave bus
);
  localparam int unsigned CW    = 16;
  localparam int unsigned AW    = 17;
  localparam int unsigned ACT_W = H_ACT_END - H_ACT_START + 1;
  localparam int unsigned ACT_H = V_ACT_END - V_ACT_START + 1;
  localparam int unsigned X_MAX = ACT_W - BOX_SIZE;
  localparam int unsigned Y_MAX = ACT_H - BOX_SIZE;
  localparam logic signed [AW-1:0] STEP_S  = AW'(STEP);
  localparam logic signed [AW-1:0] X_MAX_S = AW'(X_MAX);
  localparam logic signed [AW-1:0] Y_MAX_S = AW'(Y_MAX);

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t               state_q;
  state_t               state_nxt_c;
  logic                 frame_start_c;
  logic                 move_c;
  logic [CW-1:0]        box_x_q;
  logic [CW-1:0]        box_y_q;
  logic                 dir_x_neg_q;
  logic                 dir_y_neg_q;
  logic [CW-1:0]        box_x_nxt_c;
  logic [CW-1:0]        box_y_nxt_c;
  logic                 dir_x_neg_nxt_c;
  logic                 dir_y_neg_nxt_c;
  logic                 bounce_x_c;
  logic                 bounce_y_c;
  logic signed [AW-1:0] nx_c;
  logic signed [AW-1:0] ny_c;
  logic [AW-1:0]        px_c;
  logic [AW-1:0]        py_c;
  logic                 in_act_c;
  logic                 in_box_c;
  logic [11:0]          box_rgb_c;
  logic [11:0]          rgb_nxt_c;

  assign frame_start_c = (bus.h_count == '0) && (bus.v_count == '0);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_WAIT;
    else        state_q <= state_nxt_c;
  end

  // FSM next state; pause only matters on the frame-start cycle.
  always_comb begin
    state_nxt_c = state_q;
    case (state_q)
      ST_WAIT: if (frame_start_c)              state_nxt_c = ST_RUN;
      ST_RUN:  if (frame_start_c && bus.pause)  state_nxt_c = ST_HOLD;
      ST_HOLD: if (frame_start_c && !bus.pause) state_nxt_c = ST_RUN;
      default:                                  state_nxt_c = ST_WAIT;
    endcase
  end

  // FSM outputs: a move happens only on a running, unpaused frame start.
  always_comb begin
    move_c = 1'b0;
    if ((state_q == ST_RUN) && frame_start_c && !bus.pause) move_c = 1'b1;
  end

  // X axis step with clamp-and-reflect at both edges.
  always_comb begin
    nx_c            = dir_x_neg_q ? ($signed({1'b0, box_x_q}) - STEP_S)
                                  : ($signed({1'b0, box_x_q}) + STEP_S);
    box_x_nxt_c     = nx_c[CW-1:0];
    dir_x_neg_nxt_c = dir_x_neg_q;
    bounce_x_c      = 1'b0;
    if (nx_c > X_MAX_S) begin
      box_x_nxt_c     = CW'(X_MAX);
      dir_x_neg_nxt_c = 1'b1;
      bounce_x_c      = 1'b1;
    end else if (nx_c[AW-1]) begin
      box_x_nxt_c     = '0;
      dir_x_neg_nxt_c = 1'b0;
      bounce_x_c      = 1'b1;
    end
  end

  // Y axis step, independent of X.
  always_comb begin
    ny_c            = dir_y_neg_q ? ($signed({1'b0, box_y_q}) - STEP_S)
                                  : ($signed({1'b0, box_y_q}) + STEP_S);
    box_y_nxt_c     = ny_c[CW-1:0];
    dir_y_neg_nxt_c = dir_y_neg_q;
    bounce_y_c      = 1'b0;
    if (ny_c > Y_MAX_S) begin
      box_y_nxt_c     = CW'(Y_MAX);
      dir_y_neg_nxt_c = 1'b1;
      bounce_y_c      = 1'b1;
    end else if (ny_c[AW-1]) begin
      box_y_nxt_c     = '0;
      dir_y_neg_nxt_c = 1'b0;
      bounce_y_c      = 1'b1;
    end
  end

  // Box position and direction registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      box_x_q     <= '0;
      box_y_q     <= '0;
      dir_x_neg_q <= 1'b0;
      dir_y_neg_q <= 1'b0;
    end else if (move_c) begin
      box_x_q     <= box_x_nxt_c;
      box_y_q     <= box_y_nxt_c;
      dir_x_neg_q <= dir_x_neg_nxt_c;
      dir_y_neg_q <= dir_y_neg_nxt_c;
    end
  end

`ifdef BOUNCE_COLOR_EN
  logic inv_q;

  // Invert flag flips once per bouncing frame, even on a corner hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  inv_q <= 1'b0;
    else if (move_c && (bounce_x_c || bounce_y_c)) inv_q <= ~inv_q;
  end

  assign box_rgb_c = inv_q ? ~bus.sw : bus.sw;
`else
  assign box_rgb_c = bus.sw;
`endif

  // Pixel decision from the current counts and the pre-update box position.
  always_comb begin
    px_c      = AW'(bus.h_count) - AW'(H_ACT_START);
    py_c      = AW'(bus.v_count) - AW'(V_ACT_START);
    in_act_c  = (bus.h_count >= CW'(H_ACT_START)) && (bus.h_count <= CW'(H_ACT_END)) &&
                (bus.v_count >= CW'(V_ACT_START)) && (bus.v_count <= CW'(V_ACT_END));
    in_box_c  = (px_c >= AW'(box_x_q)) && (px_c < (AW'(box_x_q) + AW'(BOX_SIZE))) &&
                (py_c >= AW'(box_y_q)) && (py_c < (AW'(box_y_q) + AW'(BOX_SIZE)));
    rgb_nxt_c = '0;
    if (in_act_c) rgb_nxt_c = in_box_c ? box_rgb_c : BG_RGB;
  end

  // Registered pixel and frame tick outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.Red        <= '0;
      bus.Green      <= '0;
      bus.Blue       <= '0;
      bus.frame_tick <= 1'b0;
    end else begin
      bus.Red        <= rgb_nxt_c[3:0];
      bus.Green      <= rgb_nxt_c[7:4];
      bus.Blue       <= rgb_nxt_c[11:8];
      bus.frame_tick <= move_c;
    end
  end

endmodule

// File: tb/tb_bouncing_box_gen.sv
// Randomized bench for bouncing_box_gen against an integer reference model of the box motion.
`timescale 1ns/1ps
module tb_bouncing_box_gen;
  localparam int H0   = 144;
  localparam int V0   = 35;
  localparam int BOX  = 32;
  localparam int STEP = 2;
  localparam int XMAX = 640 - BOX;
  localparam int YMAX = 480 - BOX;
`ifdef BOUNCE_COLOR_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bouncing_box_gen_if bus();

  bouncing_box_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #20 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: box position, direction (+1/-1) and frame state flags.
  int m_x, m_y, m_dx, m_dy;
  bit m_started, m_hold, m_inv;

  task automatic model_reset();
    m_x = 0; m_y = 0; m_dx = 1; m_dy = 1;
    m_started = 0; m_hold = 0; m_inv = 0;
  endtask

  task automatic model_frame(input bit p, output bit moved, output bit corner);
    int nx, ny;
    bit bx, by;
    moved = 0; corner = 0; bx = 0; by = 0;
    if (!m_started) begin
      m_started = 1;
    end else if (m_hold) begin
      if (!p) m_hold = 0;
    end else if (p) begin
      m_hold = 1;
    end else begin
      moved = 1;
      nx = m_x + m_dx * STEP;
      ny = m_y + m_dy * STEP;
      if (nx > XMAX) begin nx = XMAX; m_dx = -1; bx = 1; end
      else if (nx < 0) begin nx = 0; m_dx = 1; bx = 1; end
      if (ny > YMAX) begin ny = YMAX; m_dy = -1; by = 1; end
      else if (ny < 0) begin ny = 0; m_dy = 1; by = 1; end
      m_x = nx; m_y = ny;
      if (bx || by) m_inv = !m_inv;
      corner = bx && by;
    end
  endtask

  function automatic logic [11:0] exp_rgb(input int h, input int v, input logic [11:0] s);
    int px, py;
    if (h < H0 || h > H0 + 639 || v < V0 || v > V0 + 479) return 12'h000;
    px = h - H0;
    py = v - V0;
    if (px >= m_x && px < m_x + BOX && py >= m_y && py < m_y + BOX)
      return (INV_EN && m_inv) ? ~s : s;
    return 12'h000;
  endfunction

  // Apply one cycle of inputs; returns 1 ns after the capturing edge.
  task automatic drive(input int h, input int v, input logic [11:0] s, input bit p);
    bus.h_count = 16'(h);
    bus.v_count = 16'(v);
    bus.sw      = s;
    bus.pause   = p;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 1, 12'hFFF, 0);
    drive(150, 40, 12'hFFF, 0);
    total++;
    if ({bus.Blue, bus.Green, bus.Red} !== 12'h000) begin
      bad++; $display("FAIL reset_rgb: got %h want 000", {bus.Blue, bus.Green, bus.Red});
    end
    total++;
    if (bus.frame_tick !== 1'b0) begin
      bad++; $display("FAIL reset_tick: got %b want 0", bus.frame_tick);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_first_pixel();
    bit mv, cr;
    drive(0, 0, 12'hFFF, 0);
    model_frame(0, mv, cr);
    total++;
    if (bus.frame_tick !== mv) begin
      bad++; $display("FAIL wait_to_run_tick: got %b want %b", bus.frame_tick, mv);
    end
    drive(144, 35, 12'hFFF, 0);
    total++;
    if ({bus.Blue, bus.Green, bus.Red} !== 12'hFFF) begin
      bad++; $display("FAIL first_pixel: got %h want fff", {bus.Blue, bus.Green, bus.Red});
    end
    drive(176, 35, 12'hFFF, 0);
    total++;
    if ({bus.Blue, bus.Green, bus.Red} !== 12'h000) begin
      bad++; $display("FAIL bg_pixel: got %h want 000", {bus.Blue, bus.Green, bus.Red});
    end
    drive(100, 35, 12'hFFF, 0);
    total++;
    if ({bus.Blue, bus.Green, bus.Red} !== 12'h000) begin
      bad++; $display("FAIL blank_pixel: got %h want 000", {bus.Blue, bus.Green, bus.Red});
    end
  endtask

  task automatic test_motion();
    bit mv, cr;
    int ox[7];
    int oy[7];
    logic [11:0] s, e;
    ox = '{0, -1, 31, 32, 0, 0, 31};
    oy = '{0, 0, 31, 31, -1, 32, 32};
    for (int f = 0; f < 2; f++) begin
      drive(0, 0, 12'h000, 0);
      model_frame(0, mv, cr);
      total++;
      if (bus.frame_tick !== mv) begin
        bad++; $display("FAIL motion_tick%0d: got %b want %b", f, bus.frame_tick, mv);
      end
      drive(10, 10, 12'h000, 0);
      total++;
      if (bus.frame_tick !== 1'b0) begin
        bad++; $display("FAIL motion_tick_width%0d: got %b want 0", f, bus.frame_tick);
      end
    end
    for (int i = 0; i < 7; i++) begin
      s = 12'($urandom);
      drive(H0 + m_x + ox[i], V0 + m_y + oy[i], s, 0);
      e = exp_rgb(H0 + m_x + ox[i], V0 + m_y + oy[i], s);
      total++;
      if ({bus.Blue, bus.Green, bus.Red} !== e) begin
        bad++; $display("FAIL motion_probe%0d: got %h want %h", i, {bus.Blue, bus.Green, bus.Red}, e);
      end
    end
  endtask

  task automatic test_mid_reset();
    bit mv, cr;
    drive(H0 + m_x, V0 + m_y, 12'h5A3, 0);
    #5 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.Blue, bus.Green, bus.Red} !== 12'h000) begin
      bad++; $display("FAIL async_reset_rgb: got %h want 000", {bus.Blue, bus.Green, bus.Red});
    end
    total++;
    if (bus.frame_tick !== 1'b0) begin
      bad++; $display("FAIL async_reset_tick: got %b want 0", bus.frame_tick);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    drive(0, 0, 12'h000, 0);
    model_frame(0, mv, cr);
    total++;
    if (bus.frame_tick !== mv) begin
      bad++; $display("FAIL restart_tick: got %b want %b", bus.frame_tick, mv);
    end
    drive(H0, V0, 12'h5A3, 0);
    total++;
    if ({bus.Blue, bus.Green, bus.Red} !== 12'h5A3) begin
      bad++; $display("FAIL restart_origin: got %h want 5a3", {bus.Blue, bus.Green, bus.Red});
    end
    drive(H0 + BOX, V0, 12'h5A3, 0);
    total++;
    if ({bus.Blue, bus.Green, bus.Red} !== 12'h000) begin
      bad++; $display("FAIL restart_right: got %h want 000", {bus.Blue, bus.Green, bus.Red});
    end
  endtask

  task automatic test_pause();
    bit mv, cr;
    logic [11:0] e;
    for (int f = 0; f < 7; f++) begin
      bit p;
      p = (f < 5);
      drive(0, 0, 12'h000, p);
      model_frame(p, mv, cr);
      total++;
      if (bus.frame_tick !== mv) begin
        bad++; $display("FAIL pause_tick%0d: got %b want %b", f, bus.frame_tick, mv);
      end
      drive(H0 + m_x + BOX - 1, V0 + m_y, 12'h0C3, 1);
      e = exp_rgb(H0 + m_x + BOX - 1, V0 + m_y, 12'h0C3);
      total++;
      if ({bus.Blue, bus.Green, bus.Red} !== e) begin
        bad++; $display("FAIL pause_probe%0d: got %h want %h", f, {bus.Blue, bus.Green, bus.Red}, e);
      end
    end
  endtask

  task automatic test_out_of_range();
    int hs[4];
    int vs[4];
    logic [11:0] e;
    hs = '{900, 0, 65535, 200};
    vs = '{0, 600, 65535, 525};
    for (int i = 0; i < 4; i++) begin
      drive(hs[i], vs[i], 12'hFFF, 0);
      total++;
      if ({bus.Blue, bus.Green, bus.Red} !== 12'h000 || bus.frame_tick !== 1'b0) begin
        bad++; $display("FAIL out_of_range%0d: got rgb %h tick %b want 000 0", i,
                        {bus.Blue, bus.Green, bus.Red}, bus.frame_tick);
      end
    end
    drive(H0 + m_x, V0 + m_y, 12'h9E1, 0);
    e = exp_rgb(H0 + m_x, V0 + m_y, 12'h9E1);
    total++;
    if ({bus.Blue, bus.Green, bus.Red} !== e) begin
      bad++; $display("FAIL out_of_range_pos: got %h want %h", {bus.Blue, bus.Green, bus.Red}, e);
    end
  endtask

  task automatic test_random();
    bit mv, cr, p;
    int ox[7];
    int oy[7];
    int h, v;
    logic [11:0] s, e;
    ox = '{0, -1, 31, 32, 0, 0, 31};
    oy = '{0, 0, 31, 31, -1, 32, 32};
    for (int f = 0; f < 800; f++) begin
      p = ($urandom_range(0, 9) == 0);
      drive(0, 0, 12'($urandom), p);
      model_frame(p, mv, cr);
      total++;
      if (bus.frame_tick !== mv || {bus.Blue, bus.Green, bus.Red} !== 12'h000) begin
        bad++; $display("FAIL rand_frame%0d: got tick %b rgb %h want %b 000", f, bus.frame_tick,
                        {bus.Blue, bus.Green, bus.Red}, mv);
      end
      for (int i = 0; i < 8; i++) begin
        s = 12'($urandom);
        if (i < 7) begin
          h = H0 + m_x + ox[i];
          v = V0 + m_y + oy[i];
        end else begin
          h = $urandom_range(0, 799);
          v = $urandom_range(0, 524);
          if (h == 0) h = 1;
        end
        drive(h, v, s, $urandom_range(0, 1));
        e = exp_rgb(h, v, s);
        total++;
        if ({bus.Blue, bus.Green, bus.Red} !== e || bus.frame_tick !== 1'b0) begin
          bad++; $display("FAIL rand_probe f%0d h%0d v%0d: got rgb %h tick %b want %h 0", f, h, v,
                          {bus.Blue, bus.Green, bus.Red}, bus.frame_tick, e);
        end
      end
    end
  endtask

  task automatic test_corner();
    bit mv, cr, hit;
    int n;
    logic [11:0] e;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    hit = 0;
    n = 0;
    while (!hit && n < 15000) begin
      drive(0, 0, 12'h0F0, 0);
      model_frame(0, mv, cr);
      total++;
      if (bus.frame_tick !== mv) begin
        bad++; $display("FAIL corner_tick%0d: got %b want %b", n, bus.frame_tick, mv);
      end
      hit = cr;
      n++;
    end
    total++;
    if (!hit) begin
      bad++; $display("FAIL corner_reached: got 0 want 1");
    end
    for (int k = 0; k < 2; k++) begin
      drive(H0 + m_x + 3, V0 + m_y + 3, 12'h0F0, 0);
      e = exp_rgb(H0 + m_x + 3, V0 + m_y + 3, 12'h0F0);
      total++;
      if ({bus.Blue, bus.Green, bus.Red} !== e) begin
        bad++; $display("FAIL corner_colour%0d: got %h want %h", k, {bus.Blue, bus.Green, bus.Red}, e);
      end
      hit = 0;
      n = 0;
      while (!hit && n < 1000) begin
        int ox, oy;
        ox = m_dx; oy = m_dy;
        drive(0, 0, 12'h0F0, 0);
        model_frame(0, mv, cr);
        hit = (ox != m_dx) || (oy != m_dy);
        n++;
      end
    end
  endtask

  initial begin
    bus.h_count = 16'd1;
    bus.v_count = 16'd1;
    bus.sw      = 12'h000;
    bus.pause   = 1'b0;
    test_reset();
    test_first_pixel();
    test_motion();
    test_mid_reset();
    test_pause();
    test_out_of_range();
    test_random();
    test_corner();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
